// File: rtl/bn_param_feeder.sv
`default_nettype none
// ============================================================================
// Module   : bn_param_feeder
// Brief    : Per-channel scale/bias sequencer feeding the batch-norm stage;
//            aligns each accepted feature word with its channel coefficients.
// Revision : 1.0 - initial release
// ============================================================================
module bn_param_feeder #(
    parameter int CH_MAX = 64,
    parameter int CH_W   = 6,
    parameter int PIX_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             param_wr_en,
    input  logic [CH_W-1:0]  param_wr_addr,
    input  logic [31:0]      param_wr_scale,
    input  logic [31:0]      param_wr_bias,
    input  logic             cfg_start,
    input  logic [CH_W-1:0]  cfg_last_ch,
    input  logic [PIX_W-1:0] cfg_last_pix,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      m_data_in,
    output logic [31:0]      m_data_a,
    output logic [31:0]      m_data_b,
    output logic             m_valid,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] c_LAST_CH_MAX = 32'(CH_MAX - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_last_ch;
    logic [PIX_W-1:0]  r_last_pix;
    logic [CH_W-1:0]   r_ch_cnt;
    logic [PIX_W-1:0]  r_pix_cnt;
    logic [63:0]       r_store [CH_MAX];
    logic [63:0]       w_coef;
    logic [CH_W-1:0]   w_last_ch_clip;
    logic              w_accept;
    logic              w_pix_end;
    logic              w_run_end;
    logic              w_idle;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_accept  = (r_state == ST_RUN) && s_valid;
    assign w_pix_end = (r_pix_cnt == r_last_pix);
    assign w_run_end = w_accept && w_pix_end && (r_ch_cnt == r_last_ch);

    assign s_ready = (r_state == ST_RUN);
    assign busy    = (r_state == ST_RUN);

    // Compared at 32 bits so the clip stays meaningful when CH_MAX < 2**CH_W.
    assign w_last_ch_clip = ({{(32-CH_W){1'b0}}, cfg_last_ch} > c_LAST_CH_MAX)
                          ? c_LAST_CH_MAX[CH_W-1:0] : cfg_last_ch;

    // Coefficient store deliberately has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH_MAX; i++) begin
            if (param_wr_en && w_idle && (param_wr_addr == CH_W'(i))) begin
                r_store[i] <= {param_wr_scale, param_wr_bias};
            end
        end
    end

    always_comb begin
        w_coef = '0;
        for (int i = 0; i < CH_MAX; i++) begin
            if (r_ch_cnt == CH_W'(i)) begin
                w_coef = r_store[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (cfg_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_run_end) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last_ch  <= '0;
            r_last_pix <= '0;
            r_ch_cnt   <= '0;
            r_pix_cnt  <= '0;
            m_data_in  <= '0;
            m_data_a   <= '0;
            m_data_b   <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            done       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            m_valid <= w_accept;
            m_last  <= w_run_end;
            done    <= w_run_end;
            if (w_idle && cfg_start) begin
                r_last_ch  <= w_last_ch_clip;
                r_last_pix <= cfg_last_pix;
                r_ch_cnt   <= '0;
                r_pix_cnt  <= '0;
            end
            if (w_accept) begin
                m_data_in <= s_data;
                m_data_a  <= w_coef[63:32];
                m_data_b  <= w_coef[31:0];
                if (w_pix_end) begin
                    r_pix_cnt <= '0;
                    if (r_ch_cnt != r_last_ch) begin
                        r_ch_cnt <= r_ch_cnt + 1'b1;
                    end
                end else begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bn_param_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bn_param_feeder
// Brief    : Self-checking bench for bn_param_feeder against a beat-index model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bn_param_feeder;

    localparam int CH_MAX = 4;
    localparam int CH_W   = 3;
    localparam int PIX_W  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             param_wr_en;
    logic [CH_W-1:0]  param_wr_addr;
    logic [31:0]      param_wr_scale;
    logic [31:0]      param_wr_bias;
    logic             cfg_start;
    logic [CH_W-1:0]  cfg_last_ch;
    logic [PIX_W-1:0] cfg_last_pix;
    logic [31:0]      s_data;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      m_data_in;
    logic [31:0]      m_data_a;
    logic [31:0]      m_data_b;
    logic             m_valid;
    logic             m_last;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mdl_scale [CH_MAX];
    logic [31:0] mdl_bias  [CH_MAX];

    bn_param_feeder #(.CH_MAX(CH_MAX), .CH_W(CH_W), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst),
        .param_wr_en(param_wr_en), .param_wr_addr(param_wr_addr),
        .param_wr_scale(param_wr_scale), .param_wr_bias(param_wr_bias),
        .cfg_start(cfg_start), .cfg_last_ch(cfg_last_ch), .cfg_last_pix(cfg_last_pix),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data_in(m_data_in), .m_data_a(m_data_a), .m_data_b(m_data_b),
        .m_valid(m_valid), .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input logic [31:0] sc, input logic [31:0] bi);
        param_wr_en = 1'b1; param_wr_addr = CH_W'(addr);
        param_wr_scale = sc; param_wr_bias = bi;
        tick();
        param_wr_en = 1'b0;
        mdl_scale[addr] = sc;
        mdl_bias[addr]  = bi;
    endtask

    // Starts a run from IDLE; optionally writes a coefficient in the same cycle.
    task automatic start_run(input int lc, input int lp, input bit co_write);
        int a;
        n_vec++;
        if ({s_ready, busy} !== 2'b00) begin
            n_err++; $display("FAIL idle_ready: got %b expected 00", {s_ready, busy});
        end
        cfg_start = 1'b1; cfg_last_ch = CH_W'(lc); cfg_last_pix = PIX_W'(lp);
        if (co_write) begin
            a = $urandom_range(0, CH_MAX-1);
            param_wr_en = 1'b1; param_wr_addr = CH_W'(a);
            param_wr_scale = $urandom; param_wr_bias = $urandom;
            mdl_scale[a] = param_wr_scale;
            mdl_bias[a]  = param_wr_bias;
        end
        tick();
        cfg_start = 1'b0; param_wr_en = 1'b0;
        n_vec++;
        if ({s_ready, busy} !== 2'b11) begin
            n_err++; $display("FAIL start_ready: got %b expected 11", {s_ready, busy});
        end
    endtask

    // Streams one run; expected triple for beat k comes from channel k/(lp+1).
    task automatic stream(input int lc, input int lp, input int gap_mode, input bit seq_data,
                          input int illegal_at, input int abort_after);
        int eff_lc, total, k, cyc, ch;
        bit v;
        logic [31:0] d;
        logic [98:0] exp_o;
        eff_lc = (lc > CH_MAX-1) ? CH_MAX-1 : lc;
        total  = (eff_lc + 1) * (lp + 1);
        k = 0; cyc = 0;
        while (k < total && cyc < total*20 + 50) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = seq_data ? 32'(k + 1) : $urandom;
            s_valid = v; s_data = d;
            if (k == illegal_at && v) begin
                param_wr_en = 1'b1; param_wr_addr = CH_W'($urandom_range(0, eff_lc));
                param_wr_scale = $urandom; param_wr_bias = $urandom;
                cfg_start = 1'b1; cfg_last_ch = '0; cfg_last_pix = '0;
            end
            tick();
            param_wr_en = 1'b0; cfg_start = 1'b0;
            cyc++;
            n_vec++;
            if (v) begin
                ch = k / (lp + 1);
                exp_o = {1'b1, (k == total-1), (k == total-1), d, mdl_scale[ch], mdl_bias[ch]};
                k++;
                if ({m_valid, m_last, done, m_data_in, m_data_a, m_data_b} !== exp_o) begin
                    n_err++;
                    $display("FAIL beat%0d: got v/l/d=%b%b%b in=%h a=%h b=%h expected %b in=%h a=%h b=%h",
                             k-1, m_valid, m_last, done, m_data_in, m_data_a, m_data_b,
                             exp_o[98:96], exp_o[95:64], exp_o[63:32], exp_o[31:0]);
                end
            end else if ({m_valid, m_last, done} !== 3'b000) begin
                n_err++; $display("FAIL gap_idle: got %b expected 000", {m_valid, m_last, done});
            end
            if (abort_after > 0 && k == abort_after) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        n_vec++;
        if (k < total) begin
            n_err++; $display("FAIL stream_timeout: got %0d beats expected %0d", k, total);
        end
        n_vec++;
        if ({s_ready, busy} !== 2'b00) begin
            n_err++; $display("FAIL done_ready: got %b expected 00", {s_ready, busy});
        end
        tick();
        n_vec++;
        if ({m_valid, m_last, done, s_ready, busy} !== 5'b0) begin
            n_err++; $display("FAIL after_done: got %b expected 00000",
                              {m_valid, m_last, done, s_ready, busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++;
        if ({s_ready, m_valid, m_last, busy, done, m_data_in, m_data_a, m_data_b} !== '0) begin
            n_err++; $display("FAIL reset_state: got rdy/v/l/b/d=%b%b%b%b%b in=%h a=%h b=%h expected all 0",
                              s_ready, m_valid, m_last, busy, done, m_data_in, m_data_a, m_data_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_and_stream();
        write_coef(0, 32'h3F80_0000, 32'h0000_0000);
        write_coef(1, 32'h4000_0000, 32'h3F00_0000);
        for (int i = 2; i < CH_MAX; i++) write_coef(i, $urandom, $urandom);
        start_run(1, 2, 1'b0);
        stream(1, 2, 0, 1'b1, -1, 0);
    endtask

    task automatic test_input_gaps();
        start_run(1, 2, 1'b0);
        stream(1, 2, 1, 1'b1, -1, 0);
        start_run(2, 4, 1'b0);
        stream(2, 4, 2, 1'b0, -1, 0);
    endtask

    task automatic test_illegal_cmds();
        start_run(1, 3, 1'b0);
        stream(1, 3, 0, 1'b0, 2, 0);
        start_run(1, 3, 1'b0);
        stream(1, 3, 2, 1'b0, -1, 0);
    endtask

    task automatic test_reset_mid_run();
        start_run(2, 2, 1'b0);
        stream(2, 2, 0, 1'b0, -1, 3);
        rst = 1'b1;
        tick();
        n_vec++;
        if ({s_ready, m_valid, m_last, busy, done, m_data_in, m_data_a, m_data_b} !== '0) begin
            n_err++; $display("FAIL reset_mid_run: got rdy/v/l/b/d=%b%b%b%b%b in=%h expected all 0",
                              s_ready, m_valid, m_last, busy, done, m_data_in);
        end
        rst = 1'b0;
        start_run(0, 0, 1'b0);
        stream(0, 0, 0, 1'b0, -1, 0);
    endtask

    task automatic test_clip_back_to_back();
        for (int i = 0; i < CH_MAX; i++) write_coef(i, $urandom, $urandom);
        start_run(CH_MAX + 3, 1, 1'b0);
        stream(CH_MAX + 3, 1, 2, 1'b0, -1, 0);
        start_run(2, 2, 1'b1);
        stream(2, 2, 0, 1'b0, -1, 0);
        start_run(CH_MAX - 1, 0, 1'b1);
        stream(CH_MAX - 1, 0, 0, 1'b0, -1, 0);
    endtask

    initial begin
        rst = 1'b1; param_wr_en = 1'b0; param_wr_addr = '0;
        param_wr_scale = '0; param_wr_bias = '0;
        cfg_start = 1'b0; cfg_last_ch = '0; cfg_last_pix = '0;
        s_data = '0; s_valid = 1'b0;
        test_reset();
        test_load_and_stream();
        test_input_gaps();
        test_illegal_cmds();
        test_reset_mid_run();
        test_clip_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
